// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared word width, default reset hold, and loader state encoding.
package program_loader_pkg;
   localparam int WORD_W = 16;
   localparam int DEF_RESET_HOLD = 2;
   typedef enum logic [2:0] {S_ADDR, S_LEN, S_DATA, S_HOLD, S_RUN} state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: streams base/length/words into instruction memory, then releases the CPU at base.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int RESET_HOLD = DEF_RESET_HOLD
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              reload,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic [WORD_W-1:0] pc_reset_address,
   output logic [WORD_W-1:0] loaded_count,
   output logic              busy
);
   state_t state;
   logic [WORD_W-1:0] len;
   logic [WORD_W-1:0] hold_cnt;
   assign in_ready  = state inside {S_ADDR, S_LEN, S_DATA};
   assign busy      = state != S_RUN;
   assign cpu_reset = busy;
   // loaded_count doubles as the offset of the next word from the base
   always_ff @(posedge CLK or posedge reset)
      if (reset) begin
         state            <= S_ADDR;
         len              <= '0;
         hold_cnt         <= '0;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         pc_reset_address <= '0;
         loaded_count     <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_ADDR: if (in_valid) begin
               pc_reset_address <= in_data;
               loaded_count     <= '0;
               state            <= S_LEN;
            end
            S_LEN: if (in_valid) begin
               len      <= in_data;
               hold_cnt <= '0;
               state    <= (in_data == '0) ? S_HOLD : S_DATA;
            end
            S_DATA: if (in_valid) begin
               mem_we       <= 1'b1;
               mem_addr     <= pc_reset_address + loaded_count;
               mem_wdata    <= in_data;
               loaded_count <= loaded_count + WORD_W'(loaded_count != '1);
               if (loaded_count == len - 1'b1) state <= S_HOLD;
            end
            S_HOLD:
               if (hold_cnt == WORD_W'(RESET_HOLD)) state <= S_RUN;
               else hold_cnt <= hold_cnt + 1'b1;
            S_RUN: if (reload) state <= S_ADDR;
            default: state <= S_ADDR;
         endcase
      end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames with a write scoreboard popped on every mem_we pulse.
module tb_program_loader;
   logic        CLK = 1'b0;
   logic        reset, in_valid, in_ready, reload, mem_we, cpu_reset, busy;
   logic [15:0] in_data, mem_addr, mem_wdata, pc_reset_address, loaded_count;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   program_loader dut (
      .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_reset(cpu_reset), .pc_reset_address(pc_reset_address),
      .loaded_count(loaded_count), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      logic [31:0] exp;
      if (reset) chk("we_in_reset", 32'(mem_we), 32'd0);
      if (mem_we) begin
         if (sb.size() != 0) exp = sb.pop_front();
         else exp = 'x;
         chk("write", {mem_addr, mem_wdata}, exp);
      end
   end

   task automatic send(input logic [15:0] w, input bit gap);
      int t = 0;
      if (gap) @(negedge CLK);
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && t < 50) begin
         @(negedge CLK);
         t++;
      end
      chk("ready_timeout", 32'(in_ready), 32'd1);
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
      sb.push_back({a, d});
   endtask

   task automatic do_reload();
      @(negedge CLK);
      reload = 1'b1;
      @(posedge CLK);
      #1 reload = 1'b0;
      chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
   endtask

   task automatic wait_run();
      int t = 0;
      while (cpu_reset && t < 100) begin
         @(posedge CLK);
         #1 t++;
      end
      chk("run_timeout", 32'(cpu_reset), 32'd0);
   endtask

   task automatic check_release(input string tag);
      chk({tag, "_k"}, 32'(cpu_reset), 32'd1);
      @(posedge CLK);
      #1 chk({tag, "_k1"}, 32'(cpu_reset), 32'd1);
      @(posedge CLK);
      #1 chk({tag, "_k2"}, 32'(cpu_reset), 32'd1);
      @(posedge CLK);
      #1 chk({tag, "_k3"}, 32'(cpu_reset), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      reload = 1'b0;
      #1;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_mem", {15'd0, mem_we, mem_addr}, 32'd0);
      chk("rst_pc_cnt", {pc_reset_address, loaded_count}, 32'd0);
      repeat (2) @(negedge CLK);
      reset = 1'b0;

      exp_wr(16'h0000, 16'h7001);
      exp_wr(16'h0001, 16'h7002);
      exp_wr(16'h0002, 16'h0003);
      send(16'h0000, 0);
      send(16'd3, 0);
      send(16'h7001, 0);
      send(16'h7002, 0);
      send(16'h0003, 0);
      chk("basic_count", 32'(loaded_count), 32'd3);
      chk("basic_pc", 32'(pc_reset_address), 32'h0);
      check_release("basic_release");
      chk("run_ready", 32'(in_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);

      do_reload();
      exp_wr(16'h0000, 16'h7001);
      exp_wr(16'h0001, 16'h7002);
      exp_wr(16'h0002, 16'h0003);
      send(16'h0000, 1);
      send(16'd3, 1);
      send(16'h7001, 1);
      send(16'h7002, 1);
      send(16'h0003, 1);
      wait_run();
      chk("gap_count", 32'(loaded_count), 32'd3);

      do_reload();
      send(16'h0010, 0);
      send(16'd0, 0);
      chk("zero_pc", 32'(pc_reset_address), 32'h10);
      chk("zero_count", 32'(loaded_count), 32'd0);
      check_release("zero_release");

      do_reload();
      exp_wr(16'hFFFF, 16'hAAAA);
      exp_wr(16'h0000, 16'h5555);
      send(16'hFFFF, 0);
      send(16'd2, 0);
      send(16'hAAAA, 0);
      send(16'h5555, 0);
      wait_run();
      chk("wrap_pc", 32'(pc_reset_address), 32'hFFFF);

      @(negedge CLK);
      reload = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h1234;
      @(posedge CLK);
      #1 reload = 1'b0;
      in_valid = 1'b0;
      chk("reload_rise", 32'(cpu_reset), 32'd1);
      chk("reload_ready", 32'(in_ready), 32'd1);
      chk("reload_pc_kept", 32'(pc_reset_address), 32'hFFFF);
      exp_wr(16'h0004, 16'h0003);
      send(16'h0004, 0);
      send(16'd1, 0);
      send(16'h0003, 0);
      wait_run();
      chk("reload_pc", 32'(pc_reset_address), 32'h4);
      chk("reload_count", 32'(loaded_count), 32'd1);

      do_reload();
      exp_wr(16'h0100, 16'h00A1);
      send(16'h0100, 0);
      send(16'd5, 0);
      send(16'h00A1, 0);
      send(16'h00A2, 0);
      #2 reset = 1'b1;
      #1;
      chk("mid_we", 32'(mem_we), 32'd0);
      chk("mid_addr_data", {mem_addr, mem_wdata}, 32'd0);
      chk("mid_pc_cnt", {pc_reset_address, loaded_count}, 32'd0);
      chk("mid_ready", 32'(in_ready), 32'd1);
      chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      exp_wr(16'h0200, 16'h00B1);
      exp_wr(16'h0201, 16'h00B2);
      send(16'h0200, 0);
      send(16'd2, 0);
      send(16'h00B1, 0);
      send(16'h00B2, 0);
      wait_run();
      chk("fresh_pc", 32'(pc_reset_address), 32'h200);
      chk("fresh_count", 32'(loaded_count), 32'd2);
      repeat (2) @(posedge CLK);
      #1 chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the stack processor's instruction memory. Accepts a framed stream of 16-bit words (start address, length, instruction words) over a valid/ready handshake and writes each instruction word into instruction memory. It holds the processor in reset for the whole load, then releases it with `pc_reset_address` set to the loaded start address. Sits between the host/UART word source and the `final_processor` reset and memory-write inputs.

## Interface
- `WORD_W`, 16, instruction/data/address width (fixed at 16 for this processor)
- `RESET_HOLD`, 2, cycles `cpu_reset` stays high after the final memory write, ≥1
- `CLK` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high; clears all state
- `in_valid` input 1: source presents `in_data`
- `in_ready` output 1: loader can accept a word
- `in_data` input 16: stream word
- `reload` input 1: request a new load while the processor runs
- `mem_we` output 1: instruction memory write strobe, one-cycle pulse
- `mem_addr` output 16: write address
- `mem_wdata` output 16: write data
- `cpu_reset` output 1: drives processor `reset`
- `pc_reset_address` output 16: drives processor `pc_reset_address`
- `loaded_count` output 16: instruction words written in the current load
- `busy` output 1: high in every state except S_RUN

## Operation
- A transfer occurs on a rising edge where `in_valid & in_ready`.
- States:
  - S_ADDR: first transfer latches base into `pc_reset_address`; go to S_LEN.
  - S_LEN: transfer latches length N. If N=0, go to S_HOLD; otherwise go to S_DATA.
  - S_DATA: each transfer i (0..N-1) writes `in_data` to address base+i. After the Nth transfer, go to S_HOLD.
  - S_HOLD: count RESET_HOLD cycles, then go to S_RUN.
  - S_RUN: idle.
- `in_ready` = 1 in S_ADDR, S_LEN and S_DATA. It is 0 in S_HOLD and S_RUN. It depends on state only, never on `in_valid`.
- Address arithmetic is modulo 2^16: base 0xFFFF plus 1 wraps to 0x0000.
- `loaded_count`:
  - Cleared when the S_ADDR transfer occurs.
  - Incremented on each S_DATA transfer.
  - Saturates at 0xFFFF; N=0xFFFF is legal.
- `cpu_reset` = 1 in all states except S_RUN.
- `reload` sampled high in S_RUN moves the block to S_ADDR at that edge, so `cpu_reset` rises the same edge. `reload` in any other state is ignored.
- `pc_reset_address` keeps its last latched value until the next S_ADDR transfer.

## Timing
- Reset values:
  - state S_ADDR, `in_ready`=1, `cpu_reset`=1, `busy`=1.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `pc_reset_address`=0, `loaded_count`=0.
- Write latency: for a data transfer at edge k, `mem_we`, `mem_addr` and `mem_wdata` are registered and valid in the cycle after edge k. `mem_we` drops at edge k+1 unless another transfer occurred at edge k+1.
- Back-to-back transfers sustain one write per cycle. Gaps in `in_valid` produce no writes.
- Release timing:
  - Last data transfer (or the S_LEN transfer when N=0) at edge k.
  - `cpu_reset` falls at edge k+RESET_HOLD+1.
  - With the default RESET_HOLD, `cpu_reset` is high for at least 2 full cycles after the last `mem_we` pulse.
- Reset asserted mid-load returns to reset values immediately, without waiting for a clock edge. The partial load is abandoned, and `mem_we` must never be high while `reset`=1.
- `reload` and `in_valid` high together in S_RUN: `reload` wins. The word is not accepted because `in_ready`=0.

## Structure
- The shared package holds:
  - state enum (S_ADDR, S_LEN, S_DATA, S_HOLD, S_RUN)
  - `WORD_W`
  - default RESET_HOLD
- Single flat module. The hold counter and word counter are inline; no sub-module is warranted.

## Test plan
- Basic load: stream 0x0000, 3, 0x7001, 0x7002, 0x0003 back-to-back.
  - Writes (0,0x7001), (1,0x7002), (2,0x0003) on consecutive cycles.
  - `pc_reset_address`=0, `loaded_count`=3.
  - `cpu_reset` falls 3 edges after the last accept.
- Backpressure/gaps: same frame with `in_valid` toggled every other cycle. Writes are identical in content and order, with no duplicate or skipped `mem_we`.
- Zero length: stream 0x0010, 0. No `mem_we`; `pc_reset_address`=0x0010; `cpu_reset` falls RESET_HOLD+1 edges after the length accept.
- Wrap-around: stream 0xFFFF, 2, 0xAAAA, 0x5555. Writes go to 0xFFFF and 0x0000.
- Reload: after a run, pulse `reload`, then load 0x0004, 1, 0x0003.
  - `cpu_reset` rises at the reload edge.
  - New `pc_reset_address`=4, `loaded_count`=1.
- Reset mid-load: assert `reset` after 2 of 5 data words.
  - Outputs take reset values asynchronously.
  - After deassertion, a fresh full frame loads correctly.
